div_issue_ctrl: RTL and testbench

//  EX-stage initiator for the multi-cycle divider: accepts one M-extension div/rem op from the pipeline,

---
 rtl/div_issue_ctrl_pkg.sv | 22 ++
 rtl/div_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: divider op codes and controller states.
package div_issue_ctrl_pkg;

    // Bit 2 selects 64-bit vs W op, bit 1 selects remainder, bit 0 selects unsigned.
    localparam logic [2:0] DIV_OP_DIVW  = 3'b000;
    localparam logic [2:0] DIV_OP_DIVUW = 3'b001;
    localparam logic [2:0] DIV_OP_REMW  = 3'b010;
    localparam logic [2:0] DIV_OP_REMUW = 3'b011;
    localparam logic [2:0] DIV_OP_DIV   = 3'b100;
    localparam logic [2:0] DIV_OP_DIVU  = 3'b101;
    localparam logic [2:0] DIV_OP_REM   = 3'b110;
    localparam logic [2:0] DIV_OP_REMU  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } div_ctrl_state_t;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: issues one div/rem op, stalls EX while it is in
// flight, returns the tagged result to writeback, and drains the divider when the op is flushed.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int TAG_W    = 5,
    parameter int WDOG_MAX = 96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_div,
    input  logic [2:0]       ex_div_type,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [TAG_W-1:0] ex_rd,
    input  logic             flush,
    output logic             ex_stall,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             div_start,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    output logic [2:0]       div_type,
    input  logic [XLEN-1:0]  div_result,
    input  logic             div_done,
    input  logic             div_busy,
    input  logic             div_by_zero,
    output logic             div_timeout
);

    localparam int WDOG_W = $clog2(WDOG_MAX + 1);

    div_ctrl_state_t  state_q;
    logic             done_seen_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic [TAG_W-1:0] rd_q;
    logic [XLEN-1:0]  dividend_q;
    logic [XLEN-1:0]  divisor_q;
    logic [2:0]       type_q;
    logic             wb_valid_q;
    logic [TAG_W-1:0] wb_rd_q;
    logic [XLEN-1:0]  wb_data_q;
    logic             timeout_q;

    logic div_req;
    logic done_fire;
    logic wdog_expired;
    logic unused_by_zero;

    // The divider already returns the architected value on divide-by-zero.
    assign unused_by_zero = div_by_zero;

    assign div_req      = ex_valid & ex_is_div;
    assign done_fire    = div_done & ~done_seen_q;
    assign wdog_d       = wdog_q + 1'b1;
    assign wdog_expired = (wdog_q >= WDOG_W'(WDOG_MAX - 1));

    // Start is issued combinationally so the pulse lands in the ISSUE cycle that sees the divider free.
    assign div_start = (state_q == ISSUE) & ~div_busy & ~div_done & ~flush;

    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign div_type     = type_q;
    assign div_timeout  = timeout_q;

    always_comb begin
        // NOTE: default assigned first so every path drives ex_stall and no latch is inferred.
        ex_stall = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:        ex_stall = div_req & ~flush;
                ISSUE, WAIT: ex_stall = 1'b1;
                RESP:        ex_stall = ~wb_ready;
                DRAIN:       ex_stall = div_req;
                default:     ex_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            done_seen_q <= 1'b0;
            wdog_q      <= '0;
            rd_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            type_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_seen_q <= div_done;
            case (state_q)
                IDLE: begin
                    if (div_req && !flush) begin
                        dividend_q <= ex_rs1;
                        divisor_q  <= ex_rs2;
                        type_q     <= ex_div_type;
                        rd_q       <= ex_rd;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (!div_busy && !div_done) begin
                        wdog_q  <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        // A done arriving with the flush retires the op; otherwise drain it.
                        state_q <= done_fire ? IDLE : DRAIN;
                        wdog_q  <= done_fire ? '0 : wdog_d;
                    end else if (done_fire) begin
                        wb_data_q  <= div_result;
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        wdog_q     <= '0;
                        state_q    <= RESP;
                    end else if (wdog_expired) begin
                        timeout_q <= 1'b1;
                        wdog_q    <= '0;
                        state_q   <= IDLE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                RESP: begin
                    if (flush || wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                DRAIN: begin
                    if (done_fire) begin
                        wdog_q  <= '0;
                        state_q <= IDLE;
                    end else if (wdog_expired) begin
                        timeout_q <= 1'b1;
                        wdog_q    <= '0;
                        state_q   <= IDLE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed ops against a behavioural divider stub, results checked by a
// scoreboard monitor on the writeback handshake.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    logic        clk, reset;
    logic        ex_valid, ex_is_div, flush, wb_ready;
    logic [2:0]  ex_div_type, div_type;
    logic [63:0] ex_rs1, ex_rs2, wb_data, div_dividend, div_divisor, div_result;
    logic [4:0]  ex_rd, wb_rd;
    logic        ex_stall, wb_valid, div_start, div_done, div_busy, div_by_zero, div_timeout;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start_count = 0;
    int   start_cyc = 0;
    int   done_hold = 1;
    bit   stub_hang = 0;

    div_issue_ctrl #(.XLEN(64), .TAG_W(5), .WDOG_MAX(96)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_is_div(ex_is_div), .ex_div_type(ex_div_type),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
        .ex_stall(ex_stall), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_type(div_type), .div_result(div_result), .div_done(div_done),
        .div_busy(div_busy), .div_by_zero(div_by_zero), .div_timeout(div_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M-extension reference for the divider stub.
    function automatic logic [63:0] model_div(input logic [2:0] t, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x, y, q, r, res;
        logic is_w, is_rem, is_uns;
        is_w   = ~t[2];
        is_rem = t[1];
        is_uns = t[0];
        x = a;
        y = b;
        if (is_w) begin
            x = is_uns ? {32'h0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            y = is_uns ? {32'h0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end
        if (y == 64'h0) begin
            q = '1;
            r = x;
        end else if (!is_uns && x == 64'h8000_0000_0000_0000 && y == '1) begin
            q = x;
            r = '0;
        end else if (is_uns) begin
            q = x / y;
            r = x % y;
        end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end
        res = is_rem ? r : q;
        if (is_w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic int div_latency(input logic [2:0] t, input logic [63:0] b);
        if (t[2] ? (b == 64'h0) : (b[31:0] == 32'h0)) return 2;
        return t[2] ? 67 : 35;
    endfunction

    // Divider stub: samples start at negedge, drives done/busy/result just after posedge.
    initial begin
        logic [2:0]  st_type;
        logic [63:0] st_a, st_b, st_res;
        int st_cnt, st_hold;
        bit seen;
        div_done = 1'b0; div_busy = 1'b0; div_result = '0; div_by_zero = 1'b0;
        st_cnt = 0; st_hold = 0; st_type = '0; st_a = '0; st_b = '0; st_res = '0;
        forever begin
            @(negedge clk);
            seen = div_start;
            if (div_start) begin
                start_count++;
                start_cyc = cyc;
                st_type = div_type;
                st_a = div_dividend;
                st_b = div_divisor;
            end
            if (div_done && !reset) begin
                check("opnd_dividend_stable", div_dividend, st_a);
                check("opnd_divisor_stable", div_divisor, st_b);
            end
            @(posedge clk);
            #1;
            if (reset) begin
                st_cnt = 0; st_hold = 0;
                div_done = 1'b0; div_busy = 1'b0; div_by_zero = 1'b0;
            end else if (seen) begin
                st_res   = model_div(st_type, st_a, st_b);
                st_cnt   = div_latency(st_type, st_b) - 1;
                div_busy = 1'b1;
                div_done = 1'b0;
            end else if (st_cnt > 0) begin
                if (!stub_hang) st_cnt--;
                if (st_cnt == 0) begin
                    div_done    = 1'b1;
                    div_busy    = 1'b0;
                    div_result  = st_res;
                    div_by_zero = (st_b == 64'h0);
                    st_hold     = done_hold - 1;
                end
            end else if (st_hold > 0) begin
                st_hold--;
            end else begin
                div_done    = 1'b0;
                div_by_zero = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every writeback handshake must match the oldest expected result.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 64'(wb_valid), 64'h0);
            end else begin
                e = sb_q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    task automatic present(input logic [2:0] t, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        ex_valid = 1'b1; ex_is_div = 1'b1; ex_div_type = t;
        ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_is_div = 1'b0;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (div_start) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) check("start_timeout", 64'(div_start), 64'h1);
    endtask

    // Presents an op, holds it while stalled, and reports how many cycles ex_stall was high.
    task automatic run_op(input logic [2:0] t, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp_data, input int ready_delay, output int stall_cycles);
        int  c0, held;
        bit  released;
        sb_q.push_back('{rd: rd, data: exp_data});
        c0 = start_count;
        held = 0;
        released = 0;
        stall_cycles = 0;
        wb_ready = (ready_delay == 0);
        present(t, a, b, rd);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wb_valid && !wb_ready) begin
                held++;
                check("hold_wb_data", wb_data, exp_data);
                check("hold_wb_rd", 64'(wb_rd), 64'(rd));
                check("hold_ex_stall", 64'(ex_stall), 64'h1);
            end
            if (!ex_stall) begin
                released = 1;
                break;
            end
            stall_cycles++;
            @(posedge clk);
            #1;
            if (held >= ready_delay) wb_ready = 1'b1;
        end
        if (!released) check("op_stall_timeout", 64'(ex_stall), 64'h0);
        check("start_pulses", 64'(start_count - c0), 64'h1);
        @(posedge clk);
        #1;
        idle_ex();
        wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_stall"}, 64'(ex_stall), 64'h0);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'h0);
        check({tag, "_wb_rd"}, 64'(wb_rd), 64'h0);
        check({tag, "_wb_data"}, wb_data, 64'h0);
        check({tag, "_div_start"}, 64'(div_start), 64'h0);
        check({tag, "_div_dividend"}, div_dividend, 64'h0);
        check({tag, "_div_divisor"}, div_divisor, 64'h0);
        check({tag, "_div_type"}, 64'(div_type), 64'h0);
        check({tag, "_div_timeout"}, 64'(div_timeout), 64'h0);
    endtask

    initial begin
        int sc, s, t;
        reset = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        ex_valid = 1'b0; ex_is_div = 1'b0; ex_div_type = '0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // DIV 100/7: start + 67 cycles to done, one more to RESP -> 69 stalled cycles.
        run_op(DIV_OP_DIV, 64'd100, 64'd7, 5'd5, 64'd14, 0, sc);
        check("div_stall_cycles", 64'(sc), 64'd69);

        // REMW -7 % 2 = -1, W latency 35.
        run_op(DIV_OP_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 0, sc);
        check("remw_stall_cycles", 64'(sc), 64'd37);

        // DIVU by zero, done held two cycles: one result only.
        done_hold = 2;
        run_op(DIV_OP_DIVU, 64'd1234, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 0, sc);
        check("divu0_stall_cycles", 64'(sc), 64'd4);
        done_hold = 1;

        // Writeback back-pressure for 5 cycles.
        run_op(DIV_OP_DIVU, 64'd1000, 64'd10, 5'd9, 64'd100, 5, sc);
        check("bp_stall_cycles", 64'(sc), 64'd74);

        // Flush 10 cycles after start; next DIV waits in DRAIN until the old done at S+67.
        present(DIV_OP_DIV, 64'd100, 64'd7, 5'd3);
        wait_start(s);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        idle_ex();
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_stall_drop", 64'(ex_stall), 64'h0);
        check("flush_no_wb", 64'(wb_valid), 64'h0);
        @(posedge clk);
        #1;
        run_op(DIV_OP_DIV, 64'd200, 64'd9, 5'd7, 64'd22, 0, sc);
        check("drain_start_delay", 64'(start_cyc - s), 64'd69);

        // Flush in the same cycle as done: result dropped and done consumed, no drain.
        present(DIV_OP_DIVU, 64'd5, 64'd0, 5'd4);
        wait_start(s);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        idle_ex();
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flushdone_no_wb", 64'(wb_valid), 64'h0);
        @(posedge clk);
        #1;
        run_op(DIV_OP_REM, 64'd50, 64'd0, 5'd6, 64'd50, 0, sc);
        check("after_flushdone_stall", 64'(sc), 64'd4);

        // Asynchronous reset while waiting on the divider.
        present(DIV_OP_DIV, 64'd100, 64'd7, 5'd2);
        wait_start(s);
        repeat (5) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        idle_ex();
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Divider that never completes: watchdog fires after 96 WAIT cycles.
        stub_hang = 1;
        present(DIV_OP_DIV, 64'd100, 64'd7, 5'd1);
        wait_start(s);
        @(posedge clk);
        #1 idle_ex();
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (div_timeout) begin
                t = cyc;
                break;
            end
        end
        check("wdog_cycles", 64'(t - s), 64'd97);
        check("wdog_no_wb", 64'(wb_valid), 64'h0);
        check("wdog_idle_stall", 64'(ex_stall), 64'h0);
        repeat (3) @(negedge clk);
        check("wdog_sticky", 64'(div_timeout), 64'h1);
        #2 reset = 1'b1;
        #1 check("wdog_cleared", 64'(div_timeout), 64'h0);
        stub_hang = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
